cpu_core_p: RTL and testbench
=============================

Name: cpu_core_p

Overview:
- Parametrised multi-cycle accumulator CPU core. Next generation of the team's fixed-width CPU top.
- Integrates the following, generalised in data width, address width and memory depth:
  - instruction memory and data memory
  - IR, PC, A/B/C registers, ALU and flags
  - a FETCH/EXEC state machine
- Adds over the previous generation: reset, start/halt control, conditional branches, a host load/readback port and status outputs.
- Instantiated by the SoC top; the host loads program and data, pulses start, then polls halted.

Parameters:
- DW, 16, data width of A/B; C and the ALU result are 2*DW.
- AW, 12, address width; both memories are 2**AW deep.
- OPW, 4, opcode width, fixed at 4.
- Derived: IW = OPW+AW is the instruction width. Constraint DW <= IW.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins execution at PC=0 when IDLE or HALT
- ld_we_im  in  1  host write of IM[ld_addr] <= ld_data
- ld_we_dm  in  1  host write of DM[ld_addr] <= ld_data[DW-1:0]
- ld_addr  in  AW  host load/readback address
- ld_data  in  IW  host write data
- dbg_dm_rdata  out  DW  combinational DM[ld_addr]
- busy  out  1  high in FETCH/EXEC
- halted  out  1  high in HALT
- pc  out  AW  current PC
- c_out  out  2*DW  register C
- za, zb, eq, gt, lt  out  1 each  registered flags

Behaviour:
- Reset: state=IDLE, PC=0, IR=0, A=B=C=0, all flags=0, busy=0, halted=0. Memory contents are not cleared. Reset wins over start and over every other event in the same cycle, including mid-instruction.
- Instruction format: IR[IW-1:AW] is the opcode; IR[AW-1:0] is the address/immediate field (ADR).
- Memories: reg arrays, combinational read, synchronous write.
- Host writes are honoured only in IDLE or HALT and ignored while busy. If ld_we_im and ld_we_dm are both high, both writes occur.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE or HALT with start=1 -> FETCH, PC<=0, halted<=0.
  - FETCH: IR<=IM[PC], PC<=PC+1 (wraps 2**AW-1 -> 0), then -> EXEC.
  - EXEC: perform the op; -> FETCH, or -> HALT on HLT.
  - Every instruction costs 2 cycles.
- Opcodes, all executed in EXEC:
  - 0 NOP
  - 1 LDA: A<=DM[ADR]
  - 2 LDB: B<=DM[ADR]
  - 3 STC: DM[ADR]<=C[DW-1:0]
  - 4 ADD: C<=zext(A)+zext(B)
  - 5 SUB: C<=zext(A)-zext(B), modulo 2**(2*DW)
  - 6 AND, 7 OR, 8 XOR: C<=zext(A op B)
  - 9 MUL: C<=A*B, unsigned, full 2*DW
  - A CMP: update flags only
  - B JMP: PC<=ADR
  - C JEQ: PC<=ADR if eq
  - D JGT: PC<=ADR if gt
  - E LDIC: C<=zext(ADR)
  - F HLT
- Flags: updated in EXEC of opcodes 4-A from the current A and B:
  - za=(A==0), zb=(B==0)
  - eq=(A==B), gt=(A>B), lt=(A<B), unsigned
  - Other opcodes hold the flags.
- Branches use the flag values registered before the current EXEC.
- A LDA/LDB result is visible to the following instruction.
- halted stays high until start or rst. pc is held in HALT and points past the HLT.

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: opcode 9 performs the MUL above.
- Undefined: no multiplier is synthesised. Opcode 9 executes as NOP: C and flags unchanged, 2 cycles.

Test Plan:
- Add/store/halt: DM[0x010]=7, DM[0x011]=5; IM = 1010, 2011, 4000, 3020, F000 (hex); start -> halted rises 10 cycles after the start edge; c_out=12; dbg DM[0x020]=0x000C; gt=1, eq=0, lt=0, za=0, zb=0; pc=0x005.
- MUL (CPU_MUL_EN defined): A=B=0xFFFF via LDA/LDB, then 9000 -> c_out=0xFFFE0001. Repeat with the macro undefined -> c_out unchanged, flags unchanged.
- SUB wrap: A=3, B=5, 5000 -> c_out=0xFFFFFFFE, lt=1, gt=0, eq=0.
- Branch: A=B=3; program A000, C008 at 0x002-0x003; IM[0x008]=F000 -> fetch goes 0x003 -> 0x008, halts with pc=0x009. With B=4 the branch falls through to 0x004.
- Reset mid-run: assert rst on an EXEC cycle -> next cycle busy=0, pc=0, c_out=0, flags 0. A ld_we_im issued while busy leaves IM unchanged, verified by re-running the program.
- PC wrap: IM[0]=BFFF, IM[0xFFF]=0000, IM[0x000] reached again -> pc sequence ...0xFFF, 0x000; loop runs until rst.

Source files
------------

// File: rtl/cpu_core_p.sv
// Parametrised multi-cycle accumulator CPU: IM/DM, IR/PC, A/B/C, ALU, flags, FETCH/EXEC FSM.
// Optional multiplier for opcode 9 is enabled by defining CPU_MUL_EN; otherwise opcode 9 is a NOP.
module cpu_core_p #(
    parameter int DW  = 16,
    parameter int AW  = 12,
    parameter int OPW = 4,
    localparam int IW = OPW + AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ld_we_im,
    input  logic            ld_we_dm,
    input  logic [AW-1:0]   ld_addr,
    input  logic [IW-1:0]   ld_data,
    output logic [DW-1:0]   dbg_dm_rdata,
    output logic            busy,
    output logic            halted,
    output logic [AW-1:0]   pc,
    output logic [2*DW-1:0] c_out,
    output logic            za,
    output logic            zb,
    output logic            eq,
    output logic            gt,
    output logic            lt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDA  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STC  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_MUL  = 4'h9,
        OP_CMP  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JEQ  = 4'hC,
        OP_JGT  = 4'hD,
        OP_LDIC = 4'hE,
        OP_HLT  = 4'hF
    } op_t;

    state_t          state;
    logic [IW-1:0]   ir;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] c;

    logic [IW-1:0]   im [DEPTH];
    logic [DW-1:0]   dm [DEPTH];

    op_t             op;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dm_rd;
    logic            host_ok;
    logic            stc_we;

    logic [2*DW-1:0]    alu;
    logic               c_we;
    logic               flag_we;
    logic [2*DW+AW-1:0] adr_ext;
    logic [2*DW-1:0]    a_ext;
    logic [2*DW-1:0]    b_ext;

    assign op           = op_t'(ir[IW-1:AW]);
    assign adr          = ir[AW-1:0];
    assign dm_rd        = dm[adr];
    assign dbg_dm_rdata = dm[ld_addr];
    assign c_out        = c;
    assign host_ok      = (state == S_IDLE) || (state == S_HALT);
    assign stc_we       = (state == S_EXEC) && (op == OP_STC);

    // Widened through an oversized temp so LDIC works even when AW > 2*DW.
    assign adr_ext = {{(2*DW){1'b0}}, adr};
    assign a_ext   = {{DW{1'b0}}, a};
    assign b_ext   = {{DW{1'b0}}, b};

    always_comb begin
        alu     = c;
        c_we    = 1'b0;
        flag_we = 1'b0;
        case (op)
            OP_ADD: begin
                alu = a_ext + b_ext;
                c_we = 1'b1;
                flag_we = 1'b1;
            end
            OP_SUB: begin
                alu = a_ext - b_ext;
                c_we = 1'b1;
                flag_we = 1'b1;
            end
            OP_AND: begin
                alu = {{DW{1'b0}}, a & b};
                c_we = 1'b1;
                flag_we = 1'b1;
            end
            OP_OR: begin
                alu = {{DW{1'b0}}, a | b};
                c_we = 1'b1;
                flag_we = 1'b1;
            end
            OP_XOR: begin
                alu = {{DW{1'b0}}, a ^ b};
                c_we = 1'b1;
                flag_we = 1'b1;
            end
`ifdef CPU_MUL_EN
            OP_MUL: begin
                alu = a_ext * b_ext;
                c_we = 1'b1;
                flag_we = 1'b1;
            end
`endif
            OP_CMP: begin
                flag_we = 1'b1;
            end
            OP_LDIC: begin
                alu = adr_ext[2*DW-1:0];
                c_we = 1'b1;
            end
            default: begin
                alu = c;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            za     <= 1'b0;
            zb     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        halted <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= im[pc];
                    pc    <= pc + 1'b1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_LDA) a <= dm_rd;
                    if (op == OP_LDB) b <= dm_rd;
                    if (c_we) c <= alu;
                    if (flag_we) begin
                        za <= (a == '0);
                        zb <= (b == '0);
                        eq <= (a == b);
                        gt <= (a > b);
                        lt <= (a < b);
                    end
                    // Branches see the flags registered before this EXEC.
                    if ((op == OP_JMP) || (op == OP_JEQ && eq) || (op == OP_JGT && gt))
                        pc <= adr;
                    if (op == OP_HLT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && host_ok && ld_we_im)
            im[ld_addr] <= ld_data;
    end

    // Host and STC writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (host_ok && ld_we_dm)
                dm[ld_addr] <= ld_data[DW-1:0];
            else if (stc_we)
                dm[adr] <= c[DW-1:0];
        end
    end

endmodule

// File: tb/tb_cpu_core_p.sv
// Directed bench for cpu_core_p: table of ALU/flag vectors plus hand sequences for
// cycle count, store, branches, mid-run reset, busy write-protect and PC wrap.
module tb_cpu_core_p;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int IW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            ld_we_im;
    logic            ld_we_dm;
    logic [AW-1:0]   ld_addr;
    logic [IW-1:0]   ld_data;
    logic [DW-1:0]   dbg_dm_rdata;
    logic            busy;
    logic            halted;
    logic [AW-1:0]   pc;
    logic [2*DW-1:0] c_out;
    logic            za, zb, eq, gt, lt;

    int checks = 0;
    int failures = 0;

    cpu_core_p #(.DW(DW), .AW(AW), .OPW(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_we_im(ld_we_im), .ld_we_dm(ld_we_dm),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_dm_rdata(dbg_dm_rdata), .busy(busy), .halted(halted), .pc(pc),
        .c_out(c_out), .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic [4:0]  fl;   // {za, zb, eq, gt, lt}
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wr_im(input logic [AW-1:0] ad, input logic [IW-1:0] d);
        ld_addr = ad; ld_data = d; ld_we_im = 1'b1;
        @(posedge clk); #1 ld_we_im = 1'b0;
    endtask

    task automatic wr_dm(input logic [AW-1:0] ad, input logic [IW-1:0] d);
        ld_addr = ad; ld_data = d; ld_we_dm = 1'b1;
        @(posedge clk); #1 ld_we_dm = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!halted && n < 200) begin
            @(posedge clk); #1 n++;
        end
    endtask

    task automatic run(output int n);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_halt(n);
    endtask

    task automatic chk_flags(input string nm, input logic [4:0] exp);
        chk(nm, {59'd0, za, zb, eq, gt, lt}, {59'd0, exp});
    endtask

    vec_t vecs[12];
    int   n;

    initial begin
        rst = 1'b1; start = 1'b0; ld_we_im = 1'b0; ld_we_dm = 1'b0;
        ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_c", c_out, 0);
        chk_flags("rst_flags", 5'b00000);
        rst = 1'b0;

        // ---------- table-driven ALU / flag vectors ----------
        vecs[0]  = '{4'h4, 16'h0007, 16'h0005, 32'h0000000C, 5'b00010};
        vecs[1]  = '{4'h5, 16'h0003, 16'h0005, 32'hFFFFFFFE, 5'b00001};
        vecs[2]  = '{4'h6, 16'hF0F0, 16'hFF00, 32'h0000F000, 5'b00001};
        vecs[3]  = '{4'h7, 16'h00FF, 16'h0F00, 32'h00000FFF, 5'b00001};
        vecs[4]  = '{4'h8, 16'hAAAA, 16'hAAAA, 32'h00000000, 5'b00100};
        vecs[5]  = '{4'h5, 16'h0000, 16'h0000, 32'h00000000, 5'b11100};
        vecs[6]  = '{4'h4, 16'hFFFF, 16'hFFFF, 32'h0001FFFE, 5'b00100};
        vecs[7]  = '{4'hA, 16'h0000, 16'h0009, 32'h0001FFFE, 5'b10001};
`ifdef CPU_MUL_EN
        vecs[8]  = '{4'h9, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5'b00100};
        vecs[9]  = '{4'hE, 16'h0001, 16'h0002, 32'h00000123, 5'b00100};
        vecs[10] = '{4'h0, 16'h0005, 16'h0005, 32'h00000123, 5'b00100};
`else
        vecs[8]  = '{4'h9, 16'hFFFF, 16'hFFFF, 32'h0001FFFE, 5'b10001};
        vecs[9]  = '{4'hE, 16'h0001, 16'h0002, 32'h00000123, 5'b10001};
        vecs[10] = '{4'h0, 16'h0005, 16'h0005, 32'h00000123, 5'b10001};
`endif
        vecs[11] = '{4'hA, 16'h0009, 16'h0003, 32'h00000123, 5'b00010};

        wr_im(12'h000, 16'h1010);
        wr_im(12'h001, 16'h2011);
        wr_im(12'h003, 16'hF000);
        for (int i = 0; i < 12; i++) begin
            wr_im(12'h002, {vecs[i].op, 12'h123});
            wr_dm(12'h010, vecs[i].a);
            wr_dm(12'h011, vecs[i].b);
            run(n);
            chk($sformatf("vec%0d_cycles", i), n, 8);
            chk($sformatf("vec%0d_pc", i), pc, 12'h004);
            chk($sformatf("vec%0d_c", i), c_out, vecs[i].c);
            chk_flags($sformatf("vec%0d_flags", i), vecs[i].fl);
        end

        // ---------- add / store / halt ----------
        wr_dm(12'h010, 16'h0007);
        wr_dm(12'h011, 16'h0005);
        wr_dm(12'h020, 16'h0000);
        wr_im(12'h000, 16'h1010);
        wr_im(12'h001, 16'h2011);
        wr_im(12'h002, 16'h4000);
        wr_im(12'h003, 16'h3020);
        wr_im(12'h004, 16'hF000);
        run(n);
        chk("add_cycles", n, 10);
        chk("add_halted", halted, 1);
        chk("add_busy", busy, 0);
        chk("add_c", c_out, 32'd12);
        chk("add_pc", pc, 12'h005);
        chk_flags("add_flags", 5'b00010);
        ld_addr = 12'h020; #1;
        chk("add_dm20", dbg_dm_rdata, 16'h000C);

        // ---------- both host writes in one cycle ----------
        ld_addr = 12'h030; ld_data = 16'hE0AB; ld_we_im = 1'b1; ld_we_dm = 1'b1;
        @(posedge clk); #1 ld_we_im = 1'b0; ld_we_dm = 1'b0;
        wr_im(12'h031, 16'hF000);
        wr_im(12'h000, 16'hB030);
        ld_addr = 12'h030; #1;
        chk("dual_dm", dbg_dm_rdata, 16'hE0AB);
        run(n);
        chk("dual_cycles", n, 6);
        chk("dual_c", c_out, 32'h000000AB);
        chk("dual_pc", pc, 12'h032);

        // ---------- branches ----------
        wr_im(12'h000, 16'h1010);
        wr_im(12'h001, 16'h2011);
        wr_im(12'h002, 16'hA000);
        wr_im(12'h003, 16'hC008);
        wr_im(12'h004, 16'hF000);
        wr_im(12'h008, 16'hF000);
        wr_dm(12'h010, 16'h0003);
        wr_dm(12'h011, 16'h0003);
        run(n);
        chk("jeq_taken_cycles", n, 10);
        chk("jeq_taken_pc", pc, 12'h009);
        wr_dm(12'h011, 16'h0004);
        run(n);
        chk("jeq_fall_cycles", n, 10);
        chk("jeq_fall_pc", pc, 12'h005);

        // ---------- reset on an EXEC cycle ----------
        wr_dm(12'h010, 16'h0007);
        wr_dm(12'h011, 16'h0005);
        wr_im(12'h002, 16'h4000);
        wr_im(12'h003, 16'hB003);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy_pre", busy, 1);
        chk("mid_c_pre", c_out, 32'd12);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_halted", halted, 0);
        chk("mid_pc", pc, 0);
        chk("mid_c", c_out, 0);
        chk_flags("mid_flags", 5'b00000);

        // ---------- host IM write while busy is ignored ----------
        wr_im(12'h003, 16'h3020);
        wr_im(12'h004, 16'hF000);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        ld_addr = 12'h002; ld_data = 16'h5000; ld_we_im = 1'b1;
        @(posedge clk); #1 ld_we_im = 1'b0;
        wait_halt(n);
        chk("busywr_halted", halted, 1);
        chk("busywr_c", c_out, 32'd12);
        run(n);
        chk("busywr_rerun_c", c_out, 32'd12);
        chk("busywr_rerun_pc", pc, 12'h005);

        // ---------- PC wrap ----------
        wr_im(12'h000, 16'hBFFF);
        wr_im(12'hFFF, 16'h0000);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        chk("wrap_pc1", pc, 12'h001);
        @(posedge clk); #1;
        chk("wrap_pc_fff", pc, 12'hFFF);
        @(posedge clk); #1;
        chk("wrap_pc_000", pc, 12'h000);
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_pc_fff2", pc, 12'hFFF);
        chk("wrap_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("wrap_rst_busy", busy, 0);
        chk("wrap_rst_pc", pc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
